knn_vote: RTL and testbench

- Consumer end of the distance-sort pipeline. It accepts the K nearest coupled_dist_t entries, sorted ascending, from the sorter network.
- For each entry it looks up the class label of the training point by addr, runs a sequential majority vote, and returns the predicted class with a valid/ready handshake.
- It sits between the final pair-sort stage and the chip result interface.

---
 rtl/datatypes_p.sv | 24 ++
 rtl/knn_label_table.sv | 27 ++
 rtl/knn_vote.sv | 119 +++++++++++
 tb/tb_knn_vote.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/datatypes_p.sv
// Shared types for the distance-sort pipeline and its k-NN majority-vote consumer.
package datatypes_p;

  localparam int Bit         = 12;
  localparam int NUM_CLASSES = 4;
  localparam int LBL_W       = $clog2(NUM_CLASSES);
  localparam int N_TRAIN     = 8;
  localparam int ADDR_W      = 3;
  localparam int CNT_W       = 4;

  typedef struct packed {
    logic [Bit-1:0]    d;
    logic [ADDR_W-1:0] addr;
  } coupled_dist_t;

  typedef logic [LBL_W-1:0] label_t;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    DONE
  } knn_vote_state_t;

endpackage

// File: rtl/knn_label_table.sv
// Class label of each training point: synchronous write, combinational read.
module knn_label_table
  import datatypes_p::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  label_t            wdata,
  input  logic [ADDR_W-1:0] raddr,
  output label_t            rdata
);

  label_t mem [N_TRAIN];

  // NOTE: this small table is built from flops, so it can and must be cleared by reset; a RAM macro could not be.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_TRAIN; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/knn_vote.sv
// Majority vote over the K nearest sorted neighbours; one neighbour is tallied per cycle.
module knn_vote
  import datatypes_p::*;
#(
  parameter int K = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  coupled_dist_t [K-1:0] in_nn,
  input  logic                  lbl_we,
  input  logic [ADDR_W-1:0]     lbl_waddr,
  input  label_t                lbl_wdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output label_t                out_label,
  output logic [CNT_W-1:0]      out_votes,
  output logic [ADDR_W-1:0]     out_nearest_addr
);

  localparam int IDX_W = (K > 1) ? $clog2(K) : 1;

  knn_vote_state_t   state, state_nx;
  logic [ADDR_W-1:0] nn_addr [K];
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  cnt [NUM_CLASSES];
  logic [CNT_W-1:0]  best_cnt, best_cnt_nx, cnt_inc;
  label_t            best_lbl, best_lbl_nx, cur_lbl;
  logic              last;
  logic              unused_dist;

  // Distances only matter upstream for ordering; the vote needs nothing but addresses.
  always_comb begin
    unused_dist = 1'b0;
    for (int i = 0; i < K; i++) unused_dist = unused_dist ^ (^in_nn[i].d);
  end

  knn_label_table u_table (
    .clk   (clk),
    .rst   (rst),
    .we    (lbl_we && (state == IDLE)),
    .waddr (lbl_waddr),
    .wdata (lbl_wdata),
    .raddr (nn_addr[idx]),
    .rdata (cur_lbl)
  );

  assign in_ready = (state == IDLE);
  assign last     = (idx == IDX_W'(K - 1));
  assign cnt_inc  = cnt[cur_lbl] + CNT_W'(1);

  // Strictly greater keeps the earlier (nearer) class on a tie.
  always_comb begin
    best_cnt_nx = best_cnt;
    best_lbl_nx = best_lbl;
    if (cnt_inc > best_cnt) begin
      best_cnt_nx = cnt_inc;
      best_lbl_nx = cur_lbl;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)  state_nx = COUNT;
      COUNT:   if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments here so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      idx              <= '0;
      best_cnt         <= '0;
      best_lbl         <= '0;
      out_valid        <= 1'b0;
      out_label        <= '0;
      out_votes        <= '0;
      out_nearest_addr <= '0;
      for (int i = 0; i < NUM_CLASSES; i++) cnt[i] <= '0;
      for (int i = 0; i < K; i++) nn_addr[i] <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (in_valid) begin
            idx      <= '0;
            best_cnt <= '0;
            best_lbl <= '0;
            for (int i = 0; i < NUM_CLASSES; i++) cnt[i] <= '0;
            for (int i = 0; i < K; i++) nn_addr[i] <= in_nn[i].addr;
          end
        end
        COUNT: begin
          cnt[cur_lbl] <= cnt_inc;
          best_cnt     <= best_cnt_nx;
          best_lbl     <= best_lbl_nx;
          idx          <= idx + IDX_W'(1);
          if (last) begin
            out_valid        <= 1'b1;
            out_label        <= best_lbl_nx;
            out_votes        <= best_cnt_nx;
            out_nearest_addr <= nn_addr[0];
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_knn_vote.sv
// Directed bench for knn_vote with K=3 and labels {0,1,1,2,3,0,2,1} preloaded.
module tb_knn_vote;
  import datatypes_p::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  coupled_dist_t [2:0]   in_nn;
  logic                  lbl_we;
  logic [2:0]            lbl_waddr;
  label_t                lbl_wdata;
  logic                  out_valid;
  logic                  out_ready;
  label_t                out_label;
  logic [3:0]            out_votes;
  logic [2:0]            out_nearest_addr;

  int errors = 0;
  int checks = 0;

  knn_vote #(.K(3)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_nn            (in_nn),
    .lbl_we           (lbl_we),
    .lbl_waddr        (lbl_waddr),
    .lbl_wdata        (lbl_wdata),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_label        (out_label),
    .out_votes        (out_votes),
    .out_nearest_addr (out_nearest_addr)
  );

  always #5 clk = ~clk;

  task automatic set_nn(input logic [2:0] a0, input logic [2:0] a1, input logic [2:0] a2);
    in_nn[0].d = 12'd17;  in_nn[0].addr = a0;
    in_nn[1].d = 12'd230; in_nn[1].addr = a1;
    in_nn[2].d = 12'd901; in_nn[2].addr = a2;
  endtask

  task automatic chk(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic write_label(input logic [2:0] a, input label_t l);
    @(negedge clk);
    lbl_we = 1'b1; lbl_waddr = a; lbl_wdata = l;
    @(negedge clk);
    lbl_we = 1'b0;
  endtask

  task automatic preload();
    logic [1:0] tbl [8];
    tbl = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd1};
    for (int i = 0; i < 8; i++) write_label(3'(i), tbl[i]);
  endtask

  // Returns at the negedge just after the accepting clock edge, with in_valid dropped.
  task automatic start_query(input logic [2:0] a0, input logic [2:0] a1, input logic [2:0] a2);
    int n;
    @(negedge clk);
    set_nn(a0, a1, a2);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      errors++; checks++;
      $display("FAIL start_query timeout: in_ready stayed 0");
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Cycle 1 is the cycle right after the accepting edge.
  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (!out_valid) begin
      errors++; checks++;
      $display("FAIL wait_valid timeout: out_valid stayed 0");
    end
  endtask

  task automatic check_result(input string name, input int lbl, input int votes, input int addr);
    chk({name, " out_valid"}, int'(out_valid), 1);
    chk({name, " out_label"}, int'(out_label), lbl);
    chk({name, " out_votes"}, int'(out_votes), votes);
    chk({name, " out_nearest_addr"}, int'(out_nearest_addr), addr);
  endtask

  task automatic check_released(input string name);
    @(negedge clk);
    chk({name, " out_valid after accept"}, int'(out_valid), 0);
    chk({name, " in_ready after accept"}, int'(in_ready), 1);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; lbl_we = 1'b0;
    lbl_waddr = '0; lbl_wdata = '0;
    set_nn(3'd0, 3'd0, 3'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset in_ready", int'(in_ready), 1);
    chk("reset out_label", int'(out_label), 0);
    chk("reset out_votes", int'(out_votes), 0);
    chk("reset out_nearest_addr", int'(out_nearest_addr), 0);
  endtask

  task automatic test_all_different();
    int cyc;
    out_ready = 1'b1;
    start_query(3'd2, 3'd5, 3'd6);
    wait_valid(cyc);
    chk("all_diff latency", cyc, 4);
    check_result("all_diff", 1, 1, 2);
    check_released("all_diff");
  endtask

  task automatic test_majority();
    int cyc;
    out_ready = 1'b1;
    start_query(3'd0, 3'd1, 3'd2);
    wait_valid(cyc);
    check_result("majority", 1, 2, 0);
    check_released("majority");
  endtask

  task automatic test_backpressure();
    int cyc;
    int spurious;
    out_ready = 1'b0;
    start_query(3'd0, 3'd1, 3'd2);
    wait_valid(cyc);
    for (int i = 0; i < 5; i++) begin
      check_result("backpressure hold", 1, 2, 0);
      chk("backpressure in_ready", int'(in_ready), 0);
      if (i == 1) begin
        set_nn(3'd4, 3'd4, 3'd4);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check_released("backpressure");
    spurious = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) spurious++;
    end
    chk("backpressure dropped set", spurious, 0);
  endtask

  task automatic test_write_gating();
    int cyc;
    out_ready = 1'b1;
    // Write during COUNT must be ignored.
    start_query(3'd3, 3'd3, 3'd6);
    lbl_we = 1'b1; lbl_waddr = 3'd3; lbl_wdata = 2'd3;
    @(negedge clk);
    lbl_we = 1'b0;
    wait_valid(cyc);
    check_result("gating first", 2, 3, 3);
    check_released("gating first");
    start_query(3'd3, 3'd3, 3'd6);
    wait_valid(cyc);
    check_result("gating table unchanged", 2, 3, 3);
    check_released("gating table unchanged");
    // addr4 written in IDLE; addr3 written in the handshake cycle itself.
    write_label(3'd4, 2'd3);
    @(negedge clk);
    set_nn(3'd3, 3'd3, 3'd4);
    in_valid = 1'b1;
    lbl_we = 1'b1; lbl_waddr = 3'd3; lbl_wdata = 2'd3;
    @(negedge clk);
    in_valid = 1'b0;
    lbl_we = 1'b0;
    wait_valid(cyc);
    check_result("duplicates", 3, 3, 3);
    check_released("duplicates");
  endtask

  task automatic test_reset_mid();
    int cyc;
    int spurious;
    out_ready = 1'b1;
    start_query(3'd0, 3'd1, 3'd2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("reset_mid out_valid", int'(out_valid), 0);
    chk("reset_mid in_ready", int'(in_ready), 1);
    spurious = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) spurious++;
    end
    chk("reset_mid no partial result", spurious, 0);
    start_query(3'd1, 3'd2, 3'd7);
    wait_valid(cyc);
    check_result("reset_mid cleared table", 0, 3, 1);
    check_released("reset_mid");
  endtask

  task automatic test_back_to_back();
    int     rec_cyc [4];
    int     rec_lbl [4];
    int     rec_votes [4];
    int     got;
    int     exp_votes;
    preload();
    out_ready = 1'b1;
    got = 0;
    fork
      begin
        for (int s = 0; s < 4; s++) begin
          int n;
          if (s % 2 == 0) set_nn(3'd0, 3'd1, 3'd2);
          else            set_nn(3'd2, 3'd5, 3'd6);
          in_valid = 1'b1;
          n = 0;
          while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
          end
          @(negedge clk);
        end
        in_valid = 1'b0;
      end
      begin
        int cyc;
        cyc = 0;
        while (got < 4 && cyc < 100) begin
          @(negedge clk);
          cyc++;
          if (out_valid) begin
            rec_cyc[got]   = cyc;
            rec_lbl[got]   = int'(out_label);
            rec_votes[got] = int'(out_votes);
            got++;
          end
        end
      end
    join
    in_valid = 1'b0;
    chk("b2b result count", got, 4);
    for (int i = 0; i < got; i++) begin
      exp_votes = (i % 2 == 0) ? 2 : 1;
      chk($sformatf("b2b[%0d] label", i), rec_lbl[i], 1);
      chk($sformatf("b2b[%0d] votes", i), rec_votes[i], exp_votes);
      if (i > 0) chk($sformatf("b2b[%0d] spacing", i), rec_cyc[i] - rec_cyc[i-1], 5);
    end
  endtask

  initial begin
    test_reset();
    preload();
    test_all_different();
    test_majority();
    test_backpressure();
    test_write_gating();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
